// File: rtl/trace_fabric_pkg.sv
// Shared types and default widths for the trace fabric merge/split blocks.
package trace_fabric_pkg;

    localparam int TRACE_DATA_WIDTH    = 8;
    localparam int TRACE_CHANNEL_WIDTH = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/trace_fabric_rr_arbiter.sv
// Combinational round-robin select: first requester after last_grant_i, wrapping.
module trace_fabric_rr_arbiter #(
    parameter int IDX_WIDTH = 2
) (
    input  logic [2**IDX_WIDTH-1:0] req_i,
    input  logic [IDX_WIDTH-1:0]    last_grant_i,
    output logic [IDX_WIDTH-1:0]    grant_o,
    output logic                    any_req_o
);

    localparam int N = 2**IDX_WIDTH;

    logic [IDX_WIDTH-1:0] idx;

    // Scan from the farthest offset down so the nearest requester is written last.
    // Offset N wraps to last_grant_i itself, giving it the lowest priority.
    always_comb begin
        grant_o = '0;
        idx     = '0;
        for (int k = N; k >= 1; k--) begin
            idx = last_grant_i + IDX_WIDTH'(k);
            if (req_i[idx]) begin
                grant_o = idx;
            end
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/trace_fabric_packet_mux.sv
// Packet-locked round-robin N-to-1 stream merger with a registered output stage;
// each output beat is tagged with its source index on out_channel.
module trace_fabric_packet_mux
    import trace_fabric_pkg::*;
#(
    parameter int DATA_WIDTH    = TRACE_DATA_WIDTH,
    parameter int CHANNEL_WIDTH = TRACE_CHANNEL_WIDTH,
    localparam int NUM_INPUTS   = 2**CHANNEL_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_INPUTS-1:0]            in_valid,
    output logic [NUM_INPUTS-1:0]            in_ready,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]            in_startofpacket,
    input  logic [NUM_INPUTS-1:0]            in_endofpacket,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [CHANNEL_WIDTH-1:0]         out_channel,
    output logic                             out_startofpacket,
    output logic                             out_endofpacket,
    output logic                             err_missing_sop
);

    state_t                   state_q;
    logic [CHANNEL_WIDTH-1:0] lock_idx_q;
    logic [CHANNEL_WIDTH-1:0] last_grant_q;
    logic                     out_valid_q;
    logic [DATA_WIDTH-1:0]    out_data_q;
    logic [CHANNEL_WIDTH-1:0] out_channel_q;
    logic                     out_sop_q;
    logic                     out_eop_q;
    logic                     err_missing_sop_q;

    logic                     stage_ready;
    logic                     grant_active;
    logic                     accept;
    logic                     arb_any;
    logic [CHANNEL_WIDTH-1:0] arb_grant;
    logic [CHANNEL_WIDTH-1:0] grant;
    logic                     sel_valid;
    logic [DATA_WIDTH-1:0]    sel_data;
    logic                     sel_sop;
    logic                     sel_eop;

    trace_fabric_rr_arbiter #(
        .IDX_WIDTH (CHANNEL_WIDTH)
    ) u_arb (
        .req_i        (in_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .any_req_o    (arb_any)
    );

    assign stage_ready  = out_ready || !out_valid_q;
    // While locked the grant is pinned even across source bubbles, so no other
    // source can slip a beat into the middle of a packet.
    assign grant        = (state_q == LOCKED) ? lock_idx_q : arb_grant;
    assign grant_active = (state_q == LOCKED) || arb_any;

    assign sel_valid = in_valid[grant];
    assign sel_data  = in_data[grant*DATA_WIDTH +: DATA_WIDTH];
    assign sel_sop   = in_startofpacket[grant];
    assign sel_eop   = in_endofpacket[grant];
    assign accept    = stage_ready && grant_active && sel_valid;

    generate
        for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_ready
            assign in_ready[gi] = stage_ready && grant_active
                                  && (grant == CHANNEL_WIDTH'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= IDLE;
            lock_idx_q        <= '0;
            last_grant_q      <= CHANNEL_WIDTH'(NUM_INPUTS - 1);
            out_valid_q       <= 1'b0;
            out_data_q        <= '0;
            out_channel_q     <= '0;
            out_sop_q         <= 1'b0;
            out_eop_q         <= 1'b0;
            err_missing_sop_q <= 1'b0;
        end else begin
            if (accept) begin
                out_valid_q   <= 1'b1;
                out_data_q    <= sel_data;
                out_channel_q <= grant;
                out_sop_q     <= sel_sop;
                out_eop_q     <= sel_eop;
            end else if (out_ready) begin
                out_valid_q   <= 1'b0;
            end

            if (accept) begin
                if (sel_eop) begin
                    last_grant_q <= grant;
                end
                case (state_q)
                    IDLE: begin
                        if (!sel_sop) begin
                            err_missing_sop_q <= 1'b1;
                        end
                        if (!sel_eop) begin
                            state_q    <= LOCKED;
                            lock_idx_q <= grant;
                        end
                    end
                    LOCKED: begin
                        if (sel_eop) begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign out_valid         = out_valid_q;
    assign out_data          = out_data_q;
    assign out_channel       = out_channel_q;
    assign out_startofpacket = out_sop_q;
    assign out_endofpacket   = out_eop_q;
    assign err_missing_sop   = err_missing_sop_q;

endmodule

// File: tb/tb_trace_fabric_packet_mux.sv
// Directed bench for trace_fabric_packet_mux with an output-side scoreboard.
module tb_trace_fabric_packet_mux;

    logic        clk;
    logic        reset_n;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [31:0] in_data;
    logic [3:0]  in_sop;
    logic [3:0]  in_eop;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_channel;
    logic        out_sop;
    logic        out_eop;
    logic        err_missing_sop;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    trace_fabric_packet_mux dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .in_startofpacket  (in_sop),
        .in_endofpacket    (in_eop),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_channel       (out_channel),
        .out_startofpacket (out_sop),
        .out_endofpacket   (out_eop),
        .err_missing_sop   (err_missing_sop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one beat on src, expect the given ready vector, then check it lands on the output.
    task automatic beat(input int src, input logic [7:0] d, input logic sop, input logic eop,
                        input logic [3:0] exp_ready, input string tag);
        beat_t b;
        in_valid[src]      = 1'b1;
        in_data[src*8 +: 8] = d;
        in_sop[src]        = sop;
        in_eop[src]        = eop;
        b.ch = 2'(src); b.d = d; b.sop = sop; b.eop = eop;
        exp_q.push_back(b);
        @(negedge clk);
        chk({tag, "_ready"}, 32'(in_ready), 32'(exp_ready));
        tick();
        chk({tag, "_lat_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_lat_data"}, 32'(out_data), 32'(d));
        chk({tag, "_lat_chan"}, 32'(out_channel), 32'(src));
        $display("beat %s: src=%0d data=0x%02h sop=%0b eop=%0b", tag, src, d, sop, eop);
    endtask

    task automatic drop(input int src);
        in_valid[src] = 1'b0;
        in_sop[src]   = 1'b0;
        in_eop[src]   = 1'b0;
    endtask

    // Scoreboard: every beat leaving the DUT must match the oldest expected beat.
    initial begin
        beat_t e;
        beat_t got;
        forever begin
            @(negedge clk);
            if (reset_n && out_valid && out_ready) begin
                chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e   = exp_q.pop_front();
                    got = {out_channel, out_data, out_sop, out_eop};
                    chk("sb_beat", 32'(got), 32'(e));
                    $display("out: chan=%0d data=0x%02h sop=%0b eop=%0b", out_channel, out_data, out_sop, out_eop);
                end
            end
        end
    end

    initial begin
        reset_n   = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        in_sop    = '0;
        in_eop    = '0;
        out_ready = 1'b1;
        #1 reset_n = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_chan", 32'(out_channel), 32'd0);
        chk("rst_out_sop_eop", 32'({out_sop, out_eop}), 32'd0);
        chk("rst_err", 32'(err_missing_sop), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        reset_n = 1'b1;
        tick();
        chk("idle_out_valid", 32'(out_valid), 32'd0);

        // Round-robin fairness: every source offers single-beat packets.
        in_valid = 4'hF;
        in_sop   = 4'hF;
        in_eop   = 4'hF;
        for (int k = 0; k < 8; k++) begin
            beat(k % 4, 8'(8'hA0 + k), 1'b1, 1'b1, 4'(1 << (k % 4)), "rr");
        end
        in_valid = '0;
        in_sop   = '0;
        in_eop   = '0;
        tick();

        // Single source, back-to-back packet.
        beat(2, 8'h11, 1'b1, 1'b0, 4'b0100, "t1_b1");
        beat(2, 8'h22, 1'b0, 1'b0, 4'b0100, "t1_b2");
        beat(2, 8'h33, 1'b0, 1'b1, 4'b0100, "t1_b3");
        drop(2);
        tick();

        // Packet lock: source 0 waits while source 1 bubbles mid-packet.
        beat(1, 8'h51, 1'b1, 1'b0, 4'b0010, "lk_b1");
        in_valid[0]  = 1'b1;
        in_data[7:0] = 8'h01;
        in_sop[0]    = 1'b1;
        in_eop[0]    = 1'b0;
        beat(1, 8'h52, 1'b0, 1'b0, 4'b0010, "lk_b2");
        drop(1);
        @(negedge clk);
        chk("lk_bubble1_ready", 32'(in_ready), 32'b0010);
        tick();
        @(negedge clk);
        chk("lk_bubble2_ready", 32'(in_ready), 32'b0010);
        chk("lk_bubble2_ovalid", 32'(out_valid), 32'd0);
        tick();
        beat(1, 8'h53, 1'b0, 1'b0, 4'b0010, "lk_b3");
        beat(1, 8'h54, 1'b0, 1'b1, 4'b0010, "lk_b4");
        drop(1);
        beat(0, 8'h01, 1'b1, 1'b0, 4'b0001, "lk_s0b1");
        beat(0, 8'h02, 1'b0, 1'b1, 4'b0001, "lk_s0b2");
        drop(0);
        tick();

        // Backpressure mid-packet on source 3.
        beat(3, 8'h31, 1'b1, 1'b0, 4'b1000, "bp_b1");
        out_ready     = 1'b0;
        in_data[31:24] = 8'h32;
        in_sop[3]     = 1'b0;
        in_eop[3]     = 1'b0;
        exp_q.push_back({2'd3, 8'h32, 1'b0, 1'b0});
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_stall_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_data", 32'(out_data), 32'h31);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_resume_ready", 32'(in_ready), 32'b1000);
        tick();
        chk("bp_resume_data", 32'(out_data), 32'h32);
        beat(3, 8'h33, 1'b0, 1'b1, 4'b1000, "bp_b3");
        drop(3);
        tick();

        // Missing SOP in IDLE.
        chk("pe_err_before", 32'(err_missing_sop), 32'd0);
        beat(3, 8'h3E, 1'b0, 1'b0, 4'b1000, "pe_b1");
        chk("pe_err_set", 32'(err_missing_sop), 32'd1);
        beat(3, 8'h3F, 1'b0, 1'b1, 4'b1000, "pe_b2");
        drop(3);
        repeat (3) tick();
        chk("pe_err_sticky", 32'(err_missing_sop), 32'd1);

        // Reset between beat 2 and beat 3 of a source 1 packet.
        beat(1, 8'h61, 1'b1, 1'b0, 4'b0010, "rs_b1");
        beat(1, 8'h62, 1'b0, 1'b0, 4'b0010, "rs_b2");
        reset_n = 1'b0;
        #1;
        chk("rs_async_valid", 32'(out_valid), 32'd0);
        chk("rs_async_data", 32'(out_data), 32'd0);
        chk("rs_async_err", 32'(err_missing_sop), 32'd0);
        void'(exp_q.pop_back());
        in_valid[0]  = 1'b1;
        in_data[7:0] = 8'h07;
        in_sop[0]    = 1'b1;
        in_eop[0]    = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        beat(0, 8'h07, 1'b1, 1'b1, 4'b0001, "rs_s0");
        drop(0);
        beat(1, 8'h61, 1'b1, 1'b0, 4'b0010, "rs_s1b1");
        beat(1, 8'h63, 1'b0, 1'b1, 4'b0010, "rs_s1b2");
        drop(1);
        repeat (3) tick();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
